// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master.
// State encoding, SPI mode constants and a word-width range check.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        TRANSFER = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4
    } state_t;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;

    function automatic bit data_w_ok(input int w);
        return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: divides clk by CLK_DIV per half-period while enabled.
// Ports: clk, reset, enable, cpol in; spi_clk, lead_stb, trail_stb, last_edge out.
module spi_clk_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cpol,
    output logic spi_clk,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              phase;
    logic              tick;

    // tick marks the clk edge on which SCLK toggles
    assign tick = enable && (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            phase    <= 1'b0;
        end else if (tick) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + 1'b1;
            phase    <= ~phase;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // Even-numbered toggles move away from the idle level
    assign lead_stb  = tick && !edge_cnt[0];
    assign trail_stb = tick && edge_cnt[0];
    assign last_edge = tick && (edge_cnt == EDGE_W'(2 * DATA_W - 1));
    // phase is cleared outside TRANSFER, so SCLK follows cpol immediately
    assign spi_clk   = cpol ^ phase;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one DATA_W-bit MSB-first word per start.
// Ports: start/data_wr/cs_sel/cpol/cpha request; busy/done/data_rd status; SPI pins.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_wr,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_rd,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic [2:0]        state
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("spi_master_param: DATA_W out of range 2..32");
    end

    state_t              st;
    state_t              st_nx;
    logic                accept;
    logic [DIV_W-1:0]    wait_cnt;
    logic                wait_done;
    logic [CS_W-1:0]     cs_q;
    logic                cpol_q;
    logic                cpha_q;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic                lead_stb;
    logic                trail_stb;
    logic                last_edge;
    logic                shift_stb;
    logic                sample_stb;

    spi_clk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .enable    (st == TRANSFER),
        .cpol      (cpol_q),
        .spi_clk   (spi_clk),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_edge (last_edge)
    );

    // Requests to a non-existent slave are dropped
    assign accept    = (st == IDLE) && start && (int'(cs_sel) < NUM_CS);
    assign wait_done = (wait_cnt == DIV_W'(CLK_DIV - 1));

    // cpha=0 pre-loads the MSB, so the final trailing edge must not shift
    assign shift_stb  = cpha_q ? lead_stb : (trail_stb && !last_edge);
    assign sample_stb = cpha_q ? trail_stb : lead_stb;

    always_ff @(posedge clk) begin
        if (reset) st <= IDLE;
        else       st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE:     if (accept)    st_nx = SETUP;
            SETUP:    if (wait_done) st_nx = TRANSFER;
            TRANSFER: if (last_edge) st_nx = HOLD;
            HOLD:     if (wait_done) st_nx = DONE;
            DONE:                    st_nx = IDLE;
            default:                 st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            cs_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            mosi     <= 1'b0;
            data_rd  <= '0;
        end else begin
            if ((st == SETUP || st == HOLD) && !wait_done)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            if (accept) begin
                tx_sr  <= data_wr;
                rx_sr  <= '0;
                cs_q   <= cs_sel;
                cpol_q <= cpol;
                cpha_q <= cpha;
                if (!cpha) mosi <= data_wr[DATA_W-1];
            end

            if (shift_stb) begin
                mosi  <= cpha_q ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
                tx_sr <= tx_sr << 1;
            end

            if (sample_stb)
                rx_sr <= {rx_sr[DATA_W-2:0], miso};

            if (st == HOLD && wait_done)
                data_rd <= rx_sr;
        end
    end

    always_comb begin
        cs_n = '1;
        if (st == SETUP || st == TRANSFER || st == HOLD) begin
            for (int i = 0; i < NUM_CS; i++)
                if (cs_q == CS_W'(i)) cs_n[i] = 1'b0;
        end
    end

    assign busy  = (st != IDLE);
    assign done  = (st == DONE);
    assign state = st;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: SPI modes, chip selects,
// busy/reset behaviour and a 16-bit CLK_DIV=1 loopback instance.
module tb_spi_master_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 8-bit, CLK_DIV=4, five chip selects
    logic       a_start = 0;
    logic [7:0] a_data_wr = 0;
    logic [2:0] a_cs_sel = 0;
    logic       a_cpol = 0;
    logic       a_cpha = 0;
    logic       a_busy, a_done;
    logic [7:0] a_data_rd;
    logic       a_spi_clk;
    logic [4:0] a_cs_n;
    logic       a_mosi;
    logic       a_miso = 0;
    logic [2:0] a_state;

    spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(5)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .data_wr(a_data_wr),
        .cs_sel(a_cs_sel), .cpol(a_cpol), .cpha(a_cpha), .busy(a_busy),
        .done(a_done), .data_rd(a_data_rd), .spi_clk(a_spi_clk),
        .cs_n(a_cs_n), .mosi(a_mosi), .miso(a_miso), .state(a_state)
    );

    // Instance B: 16-bit, CLK_DIV=1, loopback
    logic        b_start = 0;
    logic [15:0] b_data_wr = 0;
    logic [0:0]  b_cs_sel = 0;
    logic        b_busy, b_done;
    logic [15:0] b_data_rd;
    logic        b_spi_clk;
    logic [0:0]  b_cs_n;
    logic        b_mosi;
    logic        b_miso;
    logic [2:0]  b_state;

    assign b_miso = b_mosi;

    spi_master_param #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .data_wr(b_data_wr),
        .cs_sel(b_cs_sel), .cpol(1'b0), .cpha(1'b0), .busy(b_busy),
        .done(b_done), .data_rd(b_data_rd), .spi_clk(b_spi_clk),
        .cs_n(b_cs_n), .mosi(b_mosi), .miso(b_miso), .state(b_state)
    );

    // One transaction on A with a slave model; returns what the slave saw
    task automatic run_a(input logic [7:0] tx, input logic [2:0] sel,
                         input logic pol, input logic pha,
                         input logic [7:0] sw, input bit poke,
                         output logic [7:0] mcap, output int edges,
                         output int low, output int pulses,
                         output bit others_ok, output bit got);
        logic prev;
        logic lead;
        int   idx;
        int   k;
        @(negedge clk);
        a_data_wr = tx;
        a_cs_sel  = sel;
        a_cpol    = pol;
        a_cpha    = pha;
        a_start   = 1'b1;
        idx       = 7;
        a_miso    = pha ? 1'b0 : sw[7];
        prev      = pol;
        @(posedge clk);
        k = 0; got = 0; low = 0; pulses = 0; mcap = '0; others_ok = 1;
        while (!got && k < 400) begin
            @(negedge clk);
            if (k == 0) a_start = 1'b0;
            if (poke && k == 20) begin
                a_start   = 1'b1;
                a_data_wr = ~tx;
                a_cpol    = ~pol;
                a_cpha    = ~pha;
            end
            if (poke && k == 21) a_start = 1'b0;
            if (a_cs_n[sel] == 1'b0) low++;
            for (int i = 0; i < 5; i++)
                if (i != int'(sel) && a_cs_n[i] == 1'b0) others_ok = 0;
            if (a_spi_clk != prev) begin
                lead = (a_spi_clk != pol);
                if (lead) pulses++;
                if (lead != pha) mcap = {mcap[6:0], a_mosi};
                if (pha && lead) begin
                    a_miso = sw[idx];
                    if (idx > 0) idx--;
                end
                if (!pha && !lead) begin
                    if (idx > 0) idx--;
                    a_miso = sw[idx];
                end
                prev = a_spi_clk;
            end
            if (a_done) got = 1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        edges = k;
    endtask

    task automatic check_xfer(input string name, input logic [7:0] mcap,
                              input logic [7:0] mexp, input logic [7:0] rexp,
                              input int edges, input int pulses, input bit got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within 400 cycles", name);
        end
        checks++;
        if (mcap !== mexp) begin
            errors++;
            $display("FAIL %s mosi: got %h expected %h", name, mcap, mexp);
        end
        checks++;
        if (a_data_rd !== rexp) begin
            errors++;
            $display("FAIL %s data_rd: got %h expected %h", name, a_data_rd, rexp);
        end
        checks++;
        if (edges !== 72) begin
            errors++;
            $display("FAIL %s done latency: got %0d expected 72", name, edges);
        end
        checks++;
        if (pulses !== 8) begin
            errors++;
            $display("FAIL %s sclk pulses: got %0d expected 8", name, pulses);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_spi_clk, a_mosi} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_a_flags: got %b expected 0000",
                     {a_busy, a_done, a_spi_clk, a_mosi});
        end
        checks++;
        if (a_cs_n !== 5'h1f || a_state !== 3'd0 || a_data_rd !== 8'h00) begin
            errors++;
            $display("FAIL reset_a_regs: cs_n %b state %0d data_rd %h expected 11111 0 00",
                     a_cs_n, a_state, a_data_rd);
        end
        checks++;
        if (b_busy !== 1'b0 || b_cs_n !== 1'b1 || b_data_rd !== 16'h0) begin
            errors++;
            $display("FAIL reset_b: busy %b cs_n %b data_rd %h expected 0 1 0000",
                     b_busy, b_cs_n, b_data_rd);
        end
        reset = 1'b0;
    endtask

    task automatic test_mode0;
        logic [7:0] m;
        int e, l, p;
        bit ok, got;
        run_a(8'hAB, 3'd0, 1'b0, 1'b0, 8'h5C, 0, m, e, l, p, ok, got);
        check_xfer("mode0", m, 8'hAB, 8'h5C, e, p, got);
        checks++;
        if (l !== 72) begin
            errors++;
            $display("FAIL mode0 cs_low: got %0d expected 72", l);
        end
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_cs_n !== 5'h1f || a_data_rd !== 8'h5C) begin
            errors++;
            $display("FAIL mode0 after: busy %b cs_n %b data_rd %h expected 0 11111 5c",
                     a_busy, a_cs_n, a_data_rd);
        end
    endtask

    task automatic test_mode3;
        logic [7:0] m;
        int e, l, p;
        bit ok, got;
        run_a(8'hA5, 3'd0, 1'b1, 1'b1, 8'h3C, 0, m, e, l, p, ok, got);
        check_xfer("mode3", m, 8'hA5, 8'h3C, e, p, got);
        @(negedge clk);
        checks++;
        if (a_spi_clk !== 1'b1 || a_state !== 3'd0) begin
            errors++;
            $display("FAIL mode3 idle: spi_clk %b state %0d expected 1 0",
                     a_spi_clk, a_state);
        end
    endtask

    task automatic test_mode12;
        logic [7:0] m;
        int e, l, p;
        bit ok, got;
        run_a(8'hFF, 3'd0, 1'b0, 1'b1, 8'h00, 0, m, e, l, p, ok, got);
        check_xfer("mode1", m, 8'hFF, 8'h00, e, p, got);
        run_a(8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 0, m, e, l, p, ok, got);
        check_xfer("mode2", m, 8'h00, 8'hFF, e, p, got);
    endtask

    task automatic test_cs_decode;
        logic [7:0] m;
        int e, l, p;
        bit ok, got, stayed;
        run_a(8'h96, 3'd2, 1'b0, 1'b0, 8'h69, 0, m, e, l, p, ok, got);
        check_xfer("cs2", m, 8'h96, 8'h69, e, p, got);
        checks++;
        if (!ok || l !== 72) begin
            errors++;
            $display("FAIL cs2 select: others_high %0d low %0d expected 1 72", ok, l);
        end
        @(negedge clk);
        a_cs_sel = 3'd5;
        a_start  = 1'b1;
        stayed   = 1;
        repeat (10) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_busy !== 1'b0 || a_cs_n !== 5'h1f) stayed = 0;
        end
        checks++;
        if (!stayed) begin
            errors++;
            $display("FAIL cs5 ignore: busy or cs_n moved, expected idle");
        end
    endtask

    task automatic test_back_to_back_busy;
        logic [7:0] m;
        int e, l, p, extra;
        bit ok, got;
        run_a(8'h3E, 3'd1, 1'b0, 1'b0, 8'hD1, 1, m, e, l, p, ok, got);
        check_xfer("busy_start", m, 8'h3E, 8'hD1, e, p, got);
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (a_done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_start extra done: got %0d expected 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] m;
        int e, l, p;
        bit ok, got;
        @(negedge clk);
        a_data_wr = 8'h77;
        a_cs_sel  = 3'd1;
        a_cpol    = 1'b1;
        a_cpha    = 1'b1;
        a_start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_state !== 3'd2) begin
            errors++;
            $display("FAIL reset_mid pre: state %0d expected 2", a_state);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (a_cs_n !== 5'h1f || a_spi_clk !== 1'b0 || a_busy !== 1'b0 ||
            a_state !== 3'd0 || a_data_rd !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: cs_n %b sclk %b busy %b state %0d rd %h expected 11111 0 0 0 00",
                     a_cs_n, a_spi_clk, a_busy, a_state, a_data_rd);
        end
        run_a(8'h12, 3'd0, 1'b0, 1'b0, 8'hC3, 0, m, e, l, p, ok, got);
        check_xfer("after_reset", m, 8'h12, 8'hC3, e, p, got);
    endtask

    task automatic test_loopback;
        int k;
        @(negedge clk);
        b_data_wr = 16'hBEEF;
        b_cs_sel  = 1'b0;
        b_start   = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        b_start = 1'b0;
        while (!b_done && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        checks++;
        if (k !== 34) begin
            errors++;
            $display("FAIL loopback latency: got %0d expected 34", k);
        end
        checks++;
        if (b_data_rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL loopback data_rd: got %h expected beef", b_data_rd);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_mode12();
        test_cs_decode();
        test_back_to_back_busy();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
